// File: rtl/ariane_pkg.sv
// Shared SV39 types for the L2 TLB: PTE, PTW fill record, L2 tag and flush FSM encoding.
// vpn_match is the single size-aware VPN compare used by both lookup and SFENCE paths.
package ariane_pkg;

    localparam int unsigned VLEN       = 39;
    localparam int unsigned VPN_W      = 27;
    localparam int unsigned PPN_W      = 44;
    localparam int unsigned ASID_MAX_W = 16;
    localparam int unsigned NAPOT_BITS = 4;

    typedef struct packed {
        logic [9:0]       reserved;
        logic [PPN_W-1:0] ppn;
        logic [1:0]       rsw;
        logic             d;
        logic             a;
        logic             g;
        logic             u;
        logic             x;
        logic             w;
        logic             r;
        logic             v;
    } pte_t;

    typedef struct packed {
        logic                  valid;
        logic                  is_2M;
        logic                  is_1G;
        logic [VPN_W-1:0]      vpn;
        logic [ASID_MAX_W-1:0] asid;
        pte_t                  content;
    } tlb_update_t;

    typedef struct packed {
        logic [ASID_MAX_W-1:0] asid;
        logic [VPN_W-1:0]      vpn;
        logic                  is_napot;
        logic                  is_2M;
        logic                  is_1G;
        logic                  valid;
    } l2_tlb_tag_t;

    typedef enum logic [1:0] {
        L2_IDLE  = 2'd0,
        L2_FLUSH = 2'd1,
        L2_DONE  = 2'd2
    } l2_tlb_fsm_e;

    // Bits below the entry's page granule are don't-care.
    function automatic logic vpn_match(input l2_tlb_tag_t t, input logic [VPN_W-1:0] v);
        logic [VPN_W-1:0] m;
        m = '1;
        if (t.is_1G)         m[17:0]           = '0;
        else if (t.is_2M)    m[8:0]            = '0;
        else if (t.is_napot) m[NAPOT_BITS-1:0] = '0;
        return ((t.vpn ^ v) & m) == '0;
    endfunction

endpackage

// File: rtl/tlb_tag_match.sv
// One L2 TLB entry compare: lookup hit and SFENCE.VMA invalidate hit, both combinational.
// The caller picks which set row drives tag/is_global; no state, no backpressure.
module tlb_tag_match import ariane_pkg::*; #(
    parameter int unsigned ASID_WIDTH = 1
) (
    input  l2_tlb_tag_t           tag,
    input  logic                  is_global,
    input  logic [ASID_WIDTH-1:0] lu_asid,
    input  logic [VPN_W-1:0]      lu_vpn,
    input  logic [ASID_WIDTH-1:0] fl_asid,
    input  logic [VPN_W-1:0]      fl_vpn,
    input  logic                  fl_all_vaddr,
    output logic                  lu_hit,
    output logic                  fl_hit
);

    logic lu_asid_eq;
    logic fl_asid_eq;
    logic fl_vaddr_ok;

    assign lu_asid_eq  = tag.asid == ASID_MAX_W'(lu_asid);
    assign fl_asid_eq  = tag.asid == ASID_MAX_W'(fl_asid);
    assign fl_vaddr_ok = fl_all_vaddr | vpn_match(tag, fl_vpn);

    assign lu_hit = tag.valid & (is_global | lu_asid_eq) & vpn_match(tag, lu_vpn);
    // A zero ASID operand also reaches global entries; a non-zero one never does.
    assign fl_hit = tag.valid & fl_vaddr_ok & ((fl_asid == '0) | (~is_global & fl_asid_eq));

endmodule

// File: rtl/l2_tlb_napot.sv
// Set-associative SV39 L2 TLB (4K + 64K NAPOT) with a small fully associative 2M/1G array.
// Lookup: one-cycle registered response, stalled while flushing; SFENCE.VMA runs IDLE->FLUSH->DONE.
module l2_tlb_napot import ariane_pkg::*; #(
    parameter int unsigned SETS       = 16,
    parameter int unsigned WAYS       = 4,
    parameter int unsigned SP_ENTRIES = 4,
    parameter int unsigned ASID_WIDTH = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  lu_req_i,
    output logic                  lu_ready_o,
    input  logic [ASID_WIDTH-1:0] lu_asid_i,
    input  logic [VLEN-1:0]       lu_vaddr_i,
    output logic                  lu_valid_o,
    output logic                  lu_hit_o,
    output pte_t                  lu_content_o,
    output logic                  lu_is_2M_o,
    output logic                  lu_is_1G_o,
    output logic                  lu_is_napot_o,
    input  tlb_update_t           update_i,
    input  logic                  update_is_napot_i,
    input  logic                  flush_i,
    input  logic [ASID_WIDTH-1:0] asid_to_be_flushed_i,
    input  logic [VLEN-1:0]       vaddr_to_be_flushed_i,
    output logic                  flush_done_o
);

    localparam int unsigned SET_W = $clog2(SETS);
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned SP_W  = $clog2(SP_ENTRIES);
    localparam logic [ASID_MAX_W-1:0] ASID_MASK = ASID_MAX_W'((64'd1 << ASID_WIDTH) - 64'd1);

    l2_tlb_tag_t tags_q    [SETS][WAYS];
    pte_t        content_q [SETS][WAYS];
    logic [WAY_W-1:0] rr_q [SETS];
    l2_tlb_tag_t sp_tags_q    [SP_ENTRIES];
    pte_t        sp_content_q [SP_ENTRIES];
    logic [SP_W-1:0] sp_rr_q;

    l2_tlb_fsm_e           state_q;
    logic [ASID_WIDTH-1:0] fl_asid_q;
    logic [VPN_W-1:0]      fl_vpn_q;
    logic                  fl_all_q;
    logic                  fl_first_q;
    logic [SET_W-1:0]      fl_set_q;

    logic [VPN_W-1:0] lu_vpn;
    logic [SET_W-1:0] lu_set;
    logic [SET_W-1:0] row;
    logic             lu_acc;
    logic [11:0]      lu_offset_unused;

    assign lu_vpn           = lu_vaddr_i[VLEN-1:12];
    assign lu_offset_unused = lu_vaddr_i[11:0];
    assign lu_set           = lu_vpn[NAPOT_BITS +: SET_W];
    assign lu_ready_o       = (state_q == L2_IDLE) & ~flush_i;
    assign lu_acc           = lu_req_i & lu_ready_o;
    assign flush_done_o     = (state_q == L2_DONE);
    // Lookups are only accepted in IDLE, so the compare row can be shared with the flush walk.
    assign row = (state_q == L2_FLUSH) ? fl_set_q : lu_set;

    logic [WAYS-1:0]       way_lu_hit, way_fl_hit;
    logic [SP_ENTRIES-1:0] sp_lu_hit, sp_fl_hit;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        tlb_tag_match #(.ASID_WIDTH(ASID_WIDTH)) u_match (
            .tag          (tags_q[row][w]),
            .is_global    (content_q[row][w].g),
            .lu_asid      (lu_asid_i),
            .lu_vpn       (lu_vpn),
            .fl_asid      (fl_asid_q),
            .fl_vpn       (fl_vpn_q),
            .fl_all_vaddr (fl_all_q),
            .lu_hit       (way_lu_hit[w]),
            .fl_hit       (way_fl_hit[w])
        );
    end

    for (genvar i = 0; i < SP_ENTRIES; i++) begin : g_sp
        tlb_tag_match #(.ASID_WIDTH(ASID_WIDTH)) u_match (
            .tag          (sp_tags_q[i]),
            .is_global    (sp_content_q[i].g),
            .lu_asid      (lu_asid_i),
            .lu_vpn       (lu_vpn),
            .fl_asid      (fl_asid_q),
            .fl_vpn       (fl_vpn_q),
            .fl_all_vaddr (fl_all_q),
            .lu_hit       (sp_lu_hit[i]),
            .fl_hit       (sp_fl_hit[i])
        );
    end

    // Lowest matching way wins, then the superpage array.
    logic hit_d, napot_d, is_2M_d, is_1G_d;
    pte_t pte_d;

    always_comb begin
        hit_d   = 1'b0;
        napot_d = 1'b0;
        is_2M_d = 1'b0;
        is_1G_d = 1'b0;
        pte_d   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit_d && way_lu_hit[w]) begin
                hit_d   = 1'b1;
                pte_d   = content_q[lu_set][w];
                napot_d = tags_q[lu_set][w].is_napot;
            end
        end
        for (int i = 0; i < SP_ENTRIES; i++) begin
            if (!hit_d && sp_lu_hit[i]) begin
                hit_d   = 1'b1;
                pte_d   = sp_content_q[i];
                is_2M_d = sp_tags_q[i].is_2M;
                is_1G_d = sp_tags_q[i].is_1G;
            end
        end
        if (napot_d) pte_d.ppn[NAPOT_BITS-1:0] = lu_vpn[NAPOT_BITS-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lu_valid_o    <= 1'b0;
            lu_hit_o      <= 1'b0;
            lu_content_o  <= '0;
            lu_is_napot_o <= 1'b0;
            lu_is_2M_o    <= 1'b0;
            lu_is_1G_o    <= 1'b0;
        end else begin
            lu_valid_o    <= lu_acc;
            lu_hit_o      <= lu_acc & hit_d;
            lu_content_o  <= lu_acc ? pte_d : '0;
            lu_is_napot_o <= lu_acc & napot_d;
            lu_is_2M_o    <= lu_acc & is_2M_d;
            lu_is_1G_o    <= lu_acc & is_1G_d;
        end
    end

    // Fill target: identical tag, else lowest invalid, else round-robin victim.
    logic             fill_vld, fill_sp, way_found, sp_found;
    logic [SET_W-1:0] fill_set;
    logic [WAY_W-1:0] way_sel;
    logic [SP_W-1:0]  sp_sel;
    l2_tlb_tag_t      new_tag;

    assign fill_vld = update_i.valid & (state_q == L2_IDLE);
    assign fill_sp  = update_i.is_1G | update_i.is_2M;
    assign fill_set = update_i.vpn[NAPOT_BITS +: SET_W];

    always_comb begin
        new_tag          = '0;
        new_tag.asid     = update_i.asid & ASID_MASK;
        new_tag.vpn      = update_i.vpn;
        new_tag.is_napot = update_is_napot_i & ~fill_sp;
        new_tag.is_2M    = update_i.is_2M;
        new_tag.is_1G    = update_i.is_1G;
        new_tag.valid    = 1'b1;
        if (new_tag.is_napot) new_tag.vpn[NAPOT_BITS-1:0] = '0;

        way_sel   = rr_q[fill_set];
        way_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!way_found && tags_q[fill_set][w] == new_tag) begin
                way_sel   = WAY_W'(w);
                way_found = 1'b1;
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (!way_found && !tags_q[fill_set][w].valid) begin
                way_sel   = WAY_W'(w);
                way_found = 1'b1;
            end
        end

        sp_sel   = sp_rr_q;
        sp_found = 1'b0;
        for (int i = 0; i < SP_ENTRIES; i++) begin
            if (!sp_found && sp_tags_q[i] == new_tag) begin
                sp_sel   = SP_W'(i);
                sp_found = 1'b1;
            end
        end
        for (int i = 0; i < SP_ENTRIES; i++) begin
            if (!sp_found && !sp_tags_q[i].valid) begin
                sp_sel   = SP_W'(i);
                sp_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) tags_q[s][w] <= '0;
            end
            for (int i = 0; i < SP_ENTRIES; i++) sp_tags_q[i] <= '0;
            sp_rr_q <= '0;
        end else if (state_q == L2_FLUSH) begin
            for (int w = 0; w < WAYS; w++) begin
                if (way_fl_hit[w]) tags_q[fl_set_q][w].valid <= 1'b0;
            end
            if (fl_first_q) begin
                for (int i = 0; i < SP_ENTRIES; i++) begin
                    if (sp_fl_hit[i]) sp_tags_q[i].valid <= 1'b0;
                end
            end
        end else if (fill_vld) begin
            if (fill_sp) begin
                sp_tags_q[sp_sel] <= new_tag;
                if (!sp_found)
                    sp_rr_q <= (sp_rr_q == SP_W'(SP_ENTRIES-1)) ? '0 : sp_rr_q + SP_W'(1);
            end else begin
                tags_q[fill_set][way_sel] <= new_tag;
                if (!way_found)
                    rr_q[fill_set] <= (rr_q[fill_set] == WAY_W'(WAYS-1)) ? '0 : rr_q[fill_set] + WAY_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_vld) begin
            if (fill_sp) sp_content_q[sp_sel]          <= update_i.content;
            else         content_q[fill_set][way_sel]  <= update_i.content;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= L2_IDLE;
            fl_asid_q  <= '0;
            fl_vpn_q   <= '0;
            fl_all_q   <= 1'b0;
            fl_first_q <= 1'b0;
            fl_set_q   <= '0;
        end else begin
            case (state_q)
                L2_IDLE: begin
                    if (flush_i) begin
                        state_q    <= L2_FLUSH;
                        fl_asid_q  <= asid_to_be_flushed_i;
                        fl_vpn_q   <= vaddr_to_be_flushed_i[VLEN-1:12];
                        fl_all_q   <= (vaddr_to_be_flushed_i == '0);
                        fl_first_q <= 1'b1;
                        fl_set_q   <= (vaddr_to_be_flushed_i == '0) ? '0
                                    : vaddr_to_be_flushed_i[12+NAPOT_BITS +: SET_W];
                    end
                end
                L2_FLUSH: begin
                    fl_first_q <= 1'b0;
                    if (!fl_all_q || fl_set_q == SET_W'(SETS-1)) state_q  <= L2_DONE;
                    else                                          fl_set_q <= fl_set_q + SET_W'(1);
                end
                L2_DONE: state_q <= L2_IDLE;
                default: state_q <= L2_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_tlb_napot.sv
// Scoreboard bench for l2_tlb_napot: expected lookups are queued at accept and
// compared when lu_valid_o fires; flush latency and ready are checked inline.
module tb_l2_tlb_napot;
    import ariane_pkg::*;

    localparam int unsigned SETS = 16;
    localparam int unsigned WAYS = 4;
    localparam int unsigned SPE  = 4;
    localparam int unsigned AW   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          lu_req_i = 1'b0;
    logic          lu_ready_o;
    logic [AW-1:0] lu_asid_i = '0;
    logic [VLEN-1:0] lu_vaddr_i = '0;
    logic          lu_valid_o, lu_hit_o, lu_is_2M_o, lu_is_1G_o, lu_is_napot_o;
    pte_t          lu_content_o;
    tlb_update_t   update_i = '0;
    logic          update_is_napot_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [AW-1:0] asid_to_be_flushed_i = '0;
    logic [VLEN-1:0] vaddr_to_be_flushed_i = '0;
    logic          flush_done_o;

    always #5 clk = ~clk;

    l2_tlb_napot #(.SETS(SETS), .WAYS(WAYS), .SP_ENTRIES(SPE), .ASID_WIDTH(AW)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .lu_req_i              (lu_req_i),
        .lu_ready_o            (lu_ready_o),
        .lu_asid_i             (lu_asid_i),
        .lu_vaddr_i            (lu_vaddr_i),
        .lu_valid_o            (lu_valid_o),
        .lu_hit_o              (lu_hit_o),
        .lu_content_o          (lu_content_o),
        .lu_is_2M_o            (lu_is_2M_o),
        .lu_is_1G_o            (lu_is_1G_o),
        .lu_is_napot_o         (lu_is_napot_o),
        .update_i              (update_i),
        .update_is_napot_i     (update_is_napot_i),
        .flush_i               (flush_i),
        .asid_to_be_flushed_i  (asid_to_be_flushed_i),
        .vaddr_to_be_flushed_i (vaddr_to_be_flushed_i),
        .flush_done_o          (flush_done_o)
    );

    typedef struct {
        logic             hit;
        logic [PPN_W-1:0] ppn;
        logic             napot;
        logic             is2m;
        logic             is1g;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (lu_valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("hit", lu_hit_o, mon_e.hit);
                    if (mon_e.hit) begin
                        chk("ppn", lu_content_o.ppn, mon_e.ppn);
                        chk("is_napot", lu_is_napot_o, mon_e.napot);
                        chk("is_2M", lu_is_2M_o, mon_e.is2m);
                        chk("is_1G", lu_is_1G_o, mon_e.is1g);
                    end
                end
            end else begin
                chk("idle_outputs", {lu_hit_o, lu_is_napot_o, lu_is_2M_o, lu_is_1G_o, |lu_content_o}, 5'd0);
            end
        end
    end

    task automatic fill(input logic [VPN_W-1:0] vpn, input logic [AW-1:0] asid, input logic [PPN_W-1:0] ppn,
                        input logic g, input logic napot, input logic is2m, input logic is1g);
        tlb_update_t u;
        u = '0;
        u.valid = 1'b1;
        u.vpn = vpn;
        u.asid = ASID_MAX_W'(asid);
        u.is_2M = is2m;
        u.is_1G = is1g;
        u.content.ppn = ppn;
        u.content.g = g;
        u.content.v = 1'b1;
        u.content.r = 1'b1;
        @(negedge clk);
        update_i = u;
        update_is_napot_i = napot;
        @(posedge clk);
        #1;
        update_i = '0;
        update_is_napot_i = 1'b0;
    endtask

    task automatic lookup(input logic [AW-1:0] asid, input logic [VLEN-1:0] va, input logic hit,
                          input logic [PPN_W-1:0] ppn, input logic napot, input logic is2m, input logic is1g);
        exp_t e;
        @(negedge clk);
        lu_req_i = 1'b1;
        lu_asid_i = asid;
        lu_vaddr_i = va;
        #1;
        chk("lookup_ready", lu_ready_o, 1'b1);
        if (lu_ready_o) begin
            e.hit = hit; e.ppn = ppn; e.napot = napot; e.is2m = is2m; e.is1g = is1g;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        lu_req_i = 1'b0;
    endtask

    // A lookup is held pending for the whole flush; it must never be accepted.
    task automatic do_flush(input logic [AW-1:0] asid, input logic [VLEN-1:0] va, input int exp_cycles);
        int cyc;
        logic seen;
        @(negedge clk);
        flush_i = 1'b1;
        asid_to_be_flushed_i = asid;
        vaddr_to_be_flushed_i = va;
        lu_req_i = 1'b1;
        lu_vaddr_i = va;
        #1;
        chk("ready_at_flush", lu_ready_o, 1'b0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clk);
            cyc++;
            chk("ready_busy", lu_ready_o, 1'b0);
            if (flush_done_o) seen = 1'b1;
        end
        lu_req_i = 1'b0;
        chk("flush_done_latency", 64'(cyc), 64'(exp_cycles));
        @(negedge clk);
        chk("flush_done_pulse", flush_done_o, 1'b0);
        chk("ready_after_flush", lu_ready_o, 1'b1);
    endtask

    function automatic logic [VLEN-1:0] pva(input int i);
        logic [VPN_W-1:0] v;
        v = 27'h00030 + VPN_W'(i * 256);
        return {v, 12'h000};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int dcnt;
        repeat (2) @(negedge clk);
        chk("rst_valid", lu_valid_o, 1'b0);
        chk("rst_hit", lu_hit_o, 1'b0);
        chk("rst_done", flush_done_o, 1'b0);
        chk("rst_ready", lu_ready_o, 1'b1);
        rst_n = 1'b1;

        // basic 4K hit and ASID mismatch
        fill(27'h12345, 2'd1, 44'hABCDE, 1'b0, 1'b0, 1'b0, 1'b0);
        lookup(2'd1, 39'h12345abc, 1'b1, 44'hABCDE, 1'b0, 1'b0, 1'b0);
        lookup(2'd2, 39'h12345abc, 1'b0, 44'h0, 1'b0, 1'b0, 1'b0);

        // NAPOT: low VPN bits come from the lookup address
        fill(27'h00120, 2'd1, 44'h80000, 1'b0, 1'b1, 1'b0, 1'b0);
        lookup(2'd1, 39'h0012_7000, 1'b1, 44'h80007, 1'b1, 1'b0, 1'b0);
        lookup(2'd1, 39'h0012_F000, 1'b1, 44'h8000F, 1'b1, 1'b0, 1'b0);
        lookup(2'd1, 39'h0013_0000, 1'b0, 44'h0, 1'b0, 1'b0, 1'b0);

        // replacement in set 3
        for (int i = 0; i < 5; i++) fill(pva(i)[VLEN-1:12], 2'd1, 44'h1000 + 44'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        lookup(2'd1, pva(0), 1'b0, 44'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) lookup(2'd1, pva(i), 1'b1, 44'h1000 + 44'(i), 1'b0, 1'b0, 1'b0);
        fill(pva(2)[VLEN-1:12], 2'd1, 44'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
        lookup(2'd1, pva(2), 1'b1, 44'h2222, 1'b0, 1'b0, 1'b0);
        fill(pva(5)[VLEN-1:12], 2'd1, 44'h1005, 1'b0, 1'b0, 1'b0, 1'b0);
        lookup(2'd1, pva(1), 1'b0, 44'h0, 1'b0, 1'b0, 1'b0);
        lookup(2'd1, pva(2), 1'b1, 44'h2222, 1'b0, 1'b0, 1'b0);
        for (int i = 6; i < 9; i++) fill(pva(i)[VLEN-1:12], 2'd1, 44'h1000 + 44'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i < 5; i++) lookup(2'd1, pva(i), 1'b0, 44'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 5; i < 9; i++) lookup(2'd1, pva(i), 1'b1, 44'h1000 + 44'(i), 1'b0, 1'b0, 1'b0);

        // flush everything
        do_flush(2'd0, 39'h0, SETS + 1);
        lookup(2'd1, pva(5), 1'b0, 44'h0, 1'b0, 1'b0, 1'b0);
        lookup(2'd1, 39'h12345abc, 1'b0, 44'h0, 1'b0, 1'b0, 1'b0);
        lookup(2'd1, 39'h0012_7000, 1'b0, 44'h0, 1'b0, 1'b0, 1'b0);

        // ASID + vaddr flush: global and 1G entries survive
        fill(27'h12345, 2'd1, 44'h11111, 1'b0, 1'b0, 1'b0, 1'b0);
        fill(27'h12345, 2'd2, 44'h22222, 1'b1, 1'b0, 1'b0, 1'b0);
        fill(27'h12200, 2'd1, 44'h00400, 1'b0, 1'b0, 1'b1, 1'b0);
        fill(27'h40000, 2'd1, 44'h40000, 1'b0, 1'b0, 1'b0, 1'b1);
        lookup(2'd1, 39'h12345abc, 1'b1, 44'h11111, 1'b0, 1'b0, 1'b0);
        lookup(2'd3, 39'h12345abc, 1'b1, 44'h22222, 1'b0, 1'b0, 1'b0);
        lookup(2'd1, 39'h1220_1000, 1'b1, 44'h00400, 1'b0, 1'b1, 1'b0);
        lookup(2'd1, 39'h4000_5000, 1'b1, 44'h40000, 1'b0, 1'b0, 1'b1);
        do_flush(2'd1, 39'h12345000, 2);
        lookup(2'd1, 39'h12345abc, 1'b1, 44'h22222, 1'b0, 1'b0, 1'b0);
        lookup(2'd1, 39'h1220_1000, 1'b0, 44'h0, 1'b0, 1'b0, 1'b0);
        lookup(2'd1, 39'h4000_5000, 1'b1, 44'h40000, 1'b0, 1'b0, 1'b1);

        // lookup and fill in the same cycle sees the pre-fill state
        @(negedge clk);
        lu_req_i = 1'b1;
        lu_asid_i = 2'd1;
        lu_vaddr_i = 39'h0009_0000;
        update_i = '0;
        update_i.valid = 1'b1;
        update_i.vpn = 27'h00090;
        update_i.asid = ASID_MAX_W'(1);
        update_i.content.ppn = 44'h9000;
        update_i.content.v = 1'b1;
        #1;
        chk("same_cycle_ready", lu_ready_o, 1'b1);
        if (lu_ready_o) begin
            mon_e.hit = 1'b0; mon_e.ppn = '0; mon_e.napot = 1'b0; mon_e.is2m = 1'b0; mon_e.is1g = 1'b0;
            sb.push_back(mon_e);
        end
        @(posedge clk);
        #1;
        lu_req_i = 1'b0;
        update_i = '0;
        lookup(2'd1, 39'h0009_0000, 1'b1, 44'h9000, 1'b0, 1'b0, 1'b0);

        // reset in the middle of a full flush
        @(negedge clk);
        flush_i = 1'b1;
        asid_to_be_flushed_i = '0;
        vaddr_to_be_flushed_i = '0;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (flush_done_o) dcnt++;
        end
        chk("no_done_after_reset", 64'(dcnt), 64'd0);
        chk("ready_after_reset", lu_ready_o, 1'b1);
        lookup(2'd1, 39'h0009_0000, 1'b0, 44'h0, 1'b0, 1'b0, 1'b0);
        lookup(2'd1, 39'h4000_5000, 1'b0, 44'h0, 1'b0, 1'b0, 1'b0);
        lookup(2'd3, 39'h12345abc, 1'b0, 44'h0, 1'b0, 1'b0, 1'b0);
        do_flush(2'd1, 39'h12345000, 2);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
